seg_display: RTL
================

SEG_DISPLAY -- requirements
Module: seg_display

Interface
REQ-001 SHALL have parameter REFRESH_TICKS, default 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz).
REQ-002 SHALL have parameter BLINK_TICKS, default 25000000, clk cycles per blink half-period (2 Hz toggle at 100 MHz).
REQ-003 SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port number  input  14  binary value from the game logic, nominally 0..9999.
REQ-006 SHALL have port select  input  2  game phase: 0 mode-select, 1 counting, 2 result, 3 target-show.
REQ-007 SHALL have port mode  input  2  difficulty: 0 easy, 1 regular, 2 hard; 3 is illegal.
REQ-008 SHALL have port seg  output  7  segment lines {g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have port dp  output  1  decimal point, active-low, driven 1 (off) at all times.
REQ-010 SHALL have port an  output  4  digit anodes, active-low; an[0] is the rightmost (units) digit.

Function
REQ-011 SHALL convert number to four BCD digits with a sequential shift-add-3 converter: 1 load cycle plus 14 shift cycles, result committed to the display BCD register on cycle 15.
REQ-012 SHALL start a conversion when number differs from the last-converted value and the converter is idle; a number change during a conversion SHALL NOT abort it, and the latest value SHALL be converted immediately afterwards.
REQ-013 SHALL display "----" (seg = 7'b0111111 on all digits) while the last-converted number exceeds 9999.
REQ-014 SHALL blank leading zero digits (seg = 7'b1111111); the units digit SHALL always show, so 0 displays as "   0".
REQ-015 SHALL, in select 0, blank digits 3..1 and show mode as 0/1/2 on digit 0; mode 3 SHALL show a dash.
REQ-016 SHALL, in select 1, show number steadily.
REQ-017 SHALL, in select 2 and select 3, show number blinking: all anodes off during the blink-off half-period.
REQ-018 SHALL reset the blink phase to "on" and clear the blink counter on every select change, so a newly entered phase starts visible.
REQ-019 SHALL run a refresh counter 0..REFRESH_TICKS-1; on wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-020 SHALL register an and seg, so outputs reflect the digit index and BCD register one cycle later; exactly one anode SHALL be low when visible.
REQ-021 SHALL encode digits 0-9 with the standard active-low 7-segment patterns (0 = 7'b1000000, 8 = 7'b0000000).

Reset
REQ-022 SHALL, on rst, drive an = 4'b1111, seg = 7'b1111111, dp = 1; clear the refresh and blink counters and the digit index; set blink phase on; set the BCD register to 0000 and the converter to idle.
REQ-023 SHALL, on rst asserted mid-conversion, discard the partial result; the first conversion after reset SHALL start on the cycle after rst deasserts.

Structure
REQ-024 SHALL place the segment pattern constants (digits 0-9, dash, blank) and the select phase encodings in the shared display package.
REQ-025 SHALL implement the converter as sub-module bin2bcd (start/busy/done handshake, 14-bit in, 16-bit BCD out); scan, blink and encode logic SHALL be in seg_display.

Verification (REFRESH_TICKS=4, BLINK_TICKS=16 in the bench)
REQ-026 SHALL verify reset then number=1234, select=1 -> after 15 cycles the scan shows seg 2(1),3(2),... digits "1234" on an[3..0], each for 4 cycles.
REQ-027 SHALL verify number=7, select=1 -> an[3..1] show blank, an[0] shows 7'b1111000.
REQ-028 SHALL verify number=12000 -> all four digits show 7'b0111111.
REQ-029 SHALL verify select=0, mode=2 -> digit 0 shows 7'b0100100, digits 3..1 blank; mode=3 -> digit 0 shows a dash.
REQ-030 SHALL verify select=2, number=500 -> anodes active 16 cycles, all 4'b1111 for 16 cycles, repeating; a select change mid-off-phase restores visibility the next cycle.
REQ-031 SHALL verify number changing 100->200 on conversion cycle 5 -> display shows 100 at cycle 15, then 200 within 15 further cycles.

Source files
------------

// File: rtl/seg_display_pkg.sv
// Shared constants for the four-digit seven-segment display: segment patterns,
// game-phase encodings and converter state type.
package seg_display_pkg;

    // Segment lines are {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [13:0] MAX_SHOWN = 14'd9999;

    typedef enum logic [1:0] {
        SEL_MODE   = 2'd0,
        SEL_COUNT  = 2'd1,
        SEL_RESULT = 2'd2,
        SEL_TARGET = 2'd3
    } select_e;

    typedef enum logic {
        CV_IDLE  = 1'b0,
        CV_SHIFT = 1'b1
    } cv_state_e;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_display_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter: one load cycle, then 14
// shift cycles; done flags the final shift and bcd_out is valid alongside it.
module bin2bcd
    import seg_display_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] bin_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd_out
);

    cv_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] sr_q, sr_d;
    logic [29:0] shifted;

    // Upper 16 bits hold the BCD digits, lower 14 bits the remaining binary.
    function automatic logic [29:0] shift_step(input logic [29:0] sr);
        logic [29:0] t;
        t = sr;
        for (int i = 0; i < 4; i++) begin
            if (t[14 + 4*i +: 4] >= 4'd5) begin
                t[14 + 4*i +: 4] = t[14 + 4*i +: 4] + 4'd3;
            end
        end
        return {t[28:0], 1'b0};
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        done    = 1'b0;
        shifted = shift_step(sr_q);
        case (state_q)
            CV_IDLE: begin
                if (start) begin
                    sr_d    = {16'd0, bin_in};
                    cnt_d   = 4'd0;
                    state_d = CV_SHIFT;
                end
            end
            default: begin
                sr_d  = shifted;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    done    = 1'b1;
                    state_d = CV_IDLE;
                end
            end
        endcase
    end

    assign busy    = (state_q == CV_SHIFT);
    assign bcd_out = shifted[29:14];

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments; reset is synchronous, sampled on the clock edge.
        if (rst) begin
            state_q <= CV_IDLE;
            cnt_q   <= 4'd0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
        end
    end

endmodule

// File: rtl/seg_display.sv
// Four-digit multiplexed seven-segment driver: converts the game number to BCD,
// scans the digits, blanks leading zeros, and blinks in result/target phases.
module seg_display
    import seg_display_pkg::*;
#(
    parameter int unsigned REFRESH_TICKS = 100000,
    parameter int unsigned BLINK_TICKS   = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] number,
    input  logic [1:0]  select,
    input  logic [1:0]  mode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int RW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_TICKS - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_TICKS - 1);

    logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic [1:0]    digit_idx_q, digit_idx_d;
    logic          blink_on_q, blink_on_d;
    logic [1:0]    select_q, select_d;
    logic [13:0]   last_num_q, last_num_d;
    logic [15:0]   disp_bcd_q, disp_bcd_d;
    logic          ovf_q, ovf_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    logic          conv_start, conv_busy, conv_done;
    logic [15:0]   conv_bcd;
    select_e       sel;
    logic          blinking, visible, lead_zero;
    logic [3:0]    cur_digit;

    assign sel = select_e'(select);

    // The converter samples number when it starts; last_num_q remembers that value.
    assign conv_start = !conv_busy && (number != last_num_q);

    bin2bcd u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start   (conv_start),
        .bin_in  (number),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd_out (conv_bcd)
    );

    always_comb begin
        refresh_cnt_d = refresh_cnt_q + RW'(1);
        digit_idx_d   = digit_idx_q;
        if (refresh_cnt_q == REFRESH_LAST) begin
            refresh_cnt_d = '0;
            digit_idx_d   = digit_idx_q + 2'd1;
        end

        select_d    = select;
        blink_cnt_d = blink_cnt_q + BW'(1);
        blink_on_d  = blink_on_q;
        if (select != select_q) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = !blink_on_q;
        end

        last_num_d = conv_start ? number : last_num_q;
        disp_bcd_d = conv_done ? conv_bcd : disp_bcd_q;
        ovf_d      = conv_done ? (last_num_q > MAX_SHOWN) : ovf_q;
    end

    // Pattern for the digit currently being scanned, registered into seg/an.
    always_comb begin
        cur_digit = disp_bcd_q[{digit_idx_q, 2'b00} +: 4];
        case (digit_idx_q)
            2'd0:    lead_zero = 1'b0;
            2'd1:    lead_zero = (disp_bcd_q[15:4] == 12'd0);
            2'd2:    lead_zero = (disp_bcd_q[15:8] == 8'd0);
            default: lead_zero = (disp_bcd_q[15:12] == 4'd0);
        endcase

        // Looking at the next blink phase lets a select change show on the very next edge.
        blinking = (sel == SEL_RESULT) || (sel == SEL_TARGET);
        visible  = !blinking || blink_on_d;

        if (sel == SEL_MODE) begin
            if (digit_idx_q != 2'd0) begin
                seg_d = SEG_BLANK;
            end else if (mode == 2'd3) begin
                seg_d = SEG_DASH;
            end else begin
                seg_d = digit_seg({2'b00, mode});
            end
        end else if (ovf_q) begin
            seg_d = SEG_DASH;
        end else if (lead_zero) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = digit_seg(cur_digit);
        end

        an_d = ~(4'b0001 << digit_idx_q);
        if (!visible) begin
            an_d  = 4'b1111;
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt_q <= '0;
            blink_cnt_q   <= '0;
            digit_idx_q   <= 2'd0;
            blink_on_q    <= 1'b1;
            select_q      <= SEL_MODE;
            last_num_q    <= 14'd0;
            disp_bcd_q    <= 16'd0;
            ovf_q         <= 1'b0;
            seg_q         <= SEG_BLANK;
            an_q          <= 4'b1111;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            digit_idx_q   <= digit_idx_d;
            blink_on_q    <= blink_on_d;
            select_q      <= select_d;
            last_num_q    <= last_num_d;
            disp_bcd_q    <= disp_bcd_d;
            ovf_q         <= ovf_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = 1'b1;

endmodule
